// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type and default word width for serial_bit_feeder.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN (adds the PAR state).
package serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

`ifdef SERIAL_FEEDER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

endpackage

// File: rtl/word_fifo2.sv
// word_fifo2: two-entry word FIFO with push/pop and full/empty flags.
// A push while full and a pop while empty are ignored.
module word_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign dout    = mem[rd_ptr];

   // Storage, pointers and occupancy; a simultaneous push and pop keeps count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= !wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= !rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts parallel words through a 2-entry FIFO and emits
// them one bit per clock on j, MSB or LSB first.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN appends an even parity bit
// after each word's data bits.
//
// Handshake: a word is taken at a rising edge where din_valid && din_ready;
// din_ready is high whenever the FIFO is not full and reset is released, and
// does not depend on din_valid. The word being serialized lives in the shift
// register, not in the FIFO, so up to three words can be in flight.
module serial_bit_feeder
   import serial_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             j,
   output logic             j_valid,
   output logic             word_done,
   output state_t           dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   shreg_q;
   logic [WIDTH-1:0]   shreg_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic               par_q;
   logic               par_d;
`endif

   logic               fifo_full;
   logic               fifo_empty;
   logic [WIDTH-1:0]   fifo_head;
   logic               fifo_push;
   logic               fifo_pop;
   logic               accept;
   logic               last_bit;
   logic               word_end;
   logic               load;
   logic [WIDTH-1:0]   load_word;

   assign din_ready = rst && !fifo_full;
   assign accept    = din_valid && din_ready;
   assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);

`ifdef SERIAL_FEEDER_PARITY_EN
   assign word_end = (state_q == PAR);
`else
   assign word_end = last_bit;
`endif

   // A new word starts when the shifter is free (idle, or finishing a word)
   // and something is waiting; with an empty FIFO the incoming word bypasses
   // it so its first bit appears right after the accept edge.
   assign load      = ((state_q == IDLE) || word_end) && (!fifo_empty || accept);
   assign load_word = fifo_empty ? din : fifo_head;
   assign fifo_pop  = load && !fifo_empty;
   assign fifo_push = accept && !(load && fifo_empty);

   word_fifo2 #(
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State, shift register, bit counter (and parity) registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_FEEDER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state: shift one place per SHIFT cycle, then reload or fall idle.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (MSB_FIRST != 0) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
               shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
`ifdef SERIAL_FEEDER_PARITY_EN
               state_d = PAR;
`else
               state_d = load ? SHIFT : IDLE;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         PAR: begin
            state_d = load ? SHIFT : IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
      if (load) begin
         shreg_d = load_word;
         cnt_d   = CNT_W'(WIDTH - 1);
`ifdef SERIAL_FEEDER_PARITY_EN
         par_d   = ^load_word;
`endif
      end
   end

   // Serial outputs decoded from registered state only.
   always_comb begin
      j         = 1'b0;
      j_valid   = 1'b0;
      word_done = 1'b0;
      case (state_q)
         SHIFT: begin
            j         = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
            j_valid   = 1'b1;
            word_done = word_end;
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         PAR: begin
            j         = par_q;
            j_valid   = 1'b1;
            word_done = 1'b1;
         end
`endif
         default: begin
            j         = 1'b0;
            j_valid   = 1'b0;
            word_done = 1'b0;
         end
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: drives two feeders (MSB-first and LSB-first) with the
// same word stream and checks both against a word-level reference model.
module tb_serial_bit_feeder;
   import serial_pkg::*;

   localparam int W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int NBITS = W + 1;
`else
   localparam int NBITS = W;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         ready_m, j_m, jv_m, done_m;
   logic         ready_l, j_l, jv_l, done_l;
   state_t       st_m, st_l;

   int checks;
   int errors;

   // model state: words waiting behind the shifter, bits left of current word
   int pend;
   int rem;
   logic [1:0] exp_m [$];
   logic [1:0] exp_l [$];

   // monitor bookkeeping
   int run_len;
   int last_run;
   int ready_low;

   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(ready_m), .j(j_m), .j_valid(jv_m), .word_done(done_m),
      .dbg_state(st_m)
   );

   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(ready_l), .j(j_l), .j_valid(jv_l), .word_done(done_l),
      .dbg_state(st_l)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected stream of one word: {word_done, j} per j_valid cycle.
   task automatic push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         logic done;
         done = (i == W - 1) && (NBITS == W);
         exp_m.push_back({done, w[W-1-i]});
         exp_l.push_back({done, w[i]});
      end
      if (NBITS > W) begin
         exp_m.push_back({1'b1, ^w});
         exp_l.push_back({1'b1, ^w});
      end
   endtask

   // Reference model: a word occupies the output for NBITS cycles; up to two
   // more wait; a word accepted with nothing busy or waiting starts at once.
   initial begin
      pend = 0;
      rem  = 0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            pend = 0;
            rem  = 0;
            exp_m.delete();
            exp_l.delete();
         end else begin
            logic acc;
            logic direct;
            acc    = din_valid && (pend < 2);
            direct = 1'b0;
            if (rem > 0) rem--;
            if (rem == 0) begin
               if (pend > 0) begin
                  pend--;
                  rem = NBITS;
               end else if (acc) begin
                  rem    = NBITS;
                  direct = 1'b1;
               end
            end
            if (acc && !direct) pend++;
            if (acc) push_word(din);
         end
      end
   end

   // Monitor: compares handshake and serial outputs every cycle.
   initial begin
      run_len   = 0;
      last_run  = 0;
      ready_low = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            run_len = 0;
         end else begin
            logic [1:0] e;
            chk("din_ready_m", ready_m, pend < 2);
            chk("din_ready_l", ready_l, pend < 2);
            chk("j_valid_m", jv_m, rem > 0);
            chk("j_valid_l", jv_l, rem > 0);
            if (!ready_m) ready_low++;
            if (jv_m) begin
               run_len++;
               if (exp_m.size() == 0) begin
                  chk("bit_m_unexpected", {done_m, j_m}, 2'bxx);
               end else begin
                  e = exp_m.pop_front();
                  chk("bit_m", {done_m, j_m}, e);
               end
            end else begin
               if (run_len > 0) last_run = run_len;
               run_len = 0;
               chk("idle_m", {done_m, j_m}, 2'b00);
            end
            if (jv_l) begin
               if (exp_l.size() == 0) begin
                  chk("bit_l_unexpected", {done_l, j_l}, 2'bxx);
               end else begin
                  e = exp_l.pop_front();
                  chk("bit_l", {done_l, j_l}, e);
               end
            end else begin
               chk("idle_l", {done_l, j_l}, 2'b00);
            end
         end
      end
   end

   // Driver: present a word and hold it until the handshake completes.
   task automatic send(input logic [W-1:0] w);
      logic r;
      din       = w;
      din_valid = 1'b1;
      for (int n = 0; n < 60; n++) begin
         r = ready_m;
         @(negedge clk);
         #1;
         if (r) return;
      end
      chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_jv"}, {jv_m, jv_l}, 2'b00);
      chk({tag, "_j"}, {j_m, j_l}, 2'b00);
      chk({tag, "_done"}, {done_m, done_l}, 2'b00);
      chk({tag, "_ready"}, {ready_m, ready_l}, 2'b00);
   endtask

   initial begin
      int snap;
      int seen;
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      #1;
      reset_check("por");
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      idle(2);

      // single word, both bit orders
      send(8'h16);
      idle(NBITS + 3);
      chk("single_run", last_run, NBITS);

      // back-to-back burst with din_valid held high
      snap = ready_low;
      send(8'hA5);
      send(8'h3C);
      send(8'hFF);
      send(8'h00);
      idle(4 * NBITS + 4);
      chk("burst_run", last_run, 4 * NBITS);
      chk("burst_ready_dropped", ready_low > snap, 1);

      // reset in the middle of a word with a second word queued
      send(8'hB6);
      send(8'h5A);
      din_valid = 1'b0;
      seen = 0;
      for (int n = 0; n < 40 && seen < 5; n++) begin
         @(negedge clk);
         if (jv_m) seen++;
      end
      chk("mid_reset_reached", seen, 5);
      #1 rst = 1'b0;
      #1;
      reset_check("mid_reset");
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      chk("post_reset_ready", {ready_m, ready_l}, 2'b11);
      idle(NBITS + 4);

      // randomized traffic
      for (int k = 0; k < 120; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            send(W'($urandom_range(0, 255)));
         end else begin
            idle($urandom_range(1, 3 * NBITS));
         end
      end
      din_valid = 1'b0;

      // drain
      for (int n = 0; n < 200 && (rem > 0 || exp_m.size() > 0); n++) begin
         @(negedge clk);
      end
      idle(2);
      chk("drain_m", exp_m.size(), 0);
      chk("drain_l", exp_l.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: word width in bits, minimum 2.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 emits each word MSB first, 0 emits it LSB first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port din, input, WIDTH bits: parallel word to be serialized.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-007 The block SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have port j, output, 1 bit: serial bit stream for the downstream sequence detector.
REQ-009 The block SHALL have port j_valid, output, 1 bit: j carries a meaningful bit this cycle.
REQ-010 The block SHALL have port word_done, output, 1 bit: single-cycle pulse in the cycle the final bit of a word is on j.

Function
REQ-011 A word SHALL be accepted at a rising clk edge where din_valid && din_ready; din_ready SHALL equal !fifo_full.
REQ-012 Accepted words SHALL enter a 2-entry FIFO and be emitted in acceptance order; none SHALL be dropped or duplicated.
REQ-013 The FSM SHALL have states IDLE, SHIFT and PAR; PAR exists only when the configuration macro is set.
REQ-014 In IDLE with the FIFO non-empty, the next edge SHALL pop the head word into the shift register, load the bit counter with WIDTH-1, and enter SHIFT.
REQ-015 In SHIFT, j SHALL be the current end bit of the shift register (MSB or LSB per MSB_FIRST), j_valid SHALL be 1, and the register SHALL shift one place per clock.
REQ-016 The first bit of an accepted word SHALL appear on j in the cycle after its accept edge when the block is IDLE.
REQ-017 On the last data bit (counter==0) with no parity, word_done SHALL be 1; a non-empty FIFO SHALL be popped on that edge with SHIFT retained, giving no bubble. Otherwise the FSM SHALL go to IDLE.
REQ-018 Outside SHIFT and PAR, j SHALL be 0 and j_valid SHALL be 0.
REQ-019 A simultaneous push and pop SHALL leave the FIFO count unchanged; with the FIFO full, din_ready SHALL be 0 even if a pop occurs that cycle.
REQ-020 j, j_valid and word_done SHALL be driven from registered state and SHALL NOT depend combinationally on din or din_valid.

Reset
REQ-021 When rst is low, the block SHALL asynchronously force state IDLE, empty the FIFO, clear the shift register and counter, and drive j=0, j_valid=0, word_done=0 and din_ready=0.
REQ-022 After rst rises, din_ready SHALL be 1 from the first cycle.
REQ-023 A reset asserted mid-word SHALL abort that word and discard all FIFO contents, with no partial output after release.

Configuration
REQ-024 When macro SERIAL_FEEDER_PARITY_EN is defined, after the last data bit the FSM SHALL enter PAR for one cycle, emitting the even parity bit (XOR of the word) with j_valid=1 and word_done=1. The REQ-017 pop/IDLE decision then applies from PAR.
REQ-025 When SERIAL_FEEDER_PARITY_EN is undefined, PAR and the parity logic SHALL be absent and each word SHALL occupy exactly WIDTH j_valid cycles.

Structure
REQ-026 Package serial_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PAR) and the default word-width constant.
REQ-027 The FIFO SHALL be a sub-module named word_fifo2, with push, pop, full, empty and 2 entries of WIDTH bits.

Verification
REQ-028 Test: WIDTH=8, MSB_FIRST=1, one word 8'h16 -> j=0,0,0,1,0,1,1,0 on 8 consecutive j_valid cycles, with word_done on the 8th only.
REQ-029 Test: MSB_FIRST=0, word 8'h16 -> j=0,1,1,0,1,0,0,0.
REQ-030 Test: four words 8'hA5,8'h3C,8'hFF,8'h00 with din_valid held high -> din_ready drops while full, all 32 bits arrive in order, j_valid stays high 32 contiguous cycles, and word_done pulses every 8th cycle.
REQ-031 Test: rst driven low at bit 4 of word 8'hB6 with a second word queued -> j_valid=0 immediately, no further bits after release, and din_ready=1 in the first cycle after release.
REQ-032 Test: SERIAL_FEEDER_PARITY_EN defined, word 8'hB6 -> 8 data bits then parity bit 1, 9 j_valid cycles, and word_done on the 9th.
